// File: rtl/axis_pkg.sv
// Shared helpers for AXI-Stream width converters.
// Contents:
//   MAX_LANES      - widest lane mask the helpers accept
//   LANE_IDX_W     - width of a lane index returned by lowest_set_idx
//   lowest_set_idx - index of the lowest set bit of a lane mask (0 when empty)
//   is_one_hot     - true when exactly one bit of a lane mask is set
package axis_pkg;

  localparam int MAX_LANES  = 32;
  localparam int LANE_IDX_W = $clog2(MAX_LANES);

  function automatic logic [LANE_IDX_W-1:0] lowest_set_idx(input logic [MAX_LANES-1:0] v);
    logic [LANE_IDX_W-1:0] idx;
    idx = '0;
    // Scanning from the top down lets the last hit, the lowest bit, win.
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (v[i]) idx = LANE_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_one_hot(input logic [MAX_LANES-1:0] v);
    return (v != '0) && ((v & (v - MAX_LANES'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_lane_sel.sv
// Lane selector: picks the lowest remaining lane of a held beat.
// Ports:
//   mask   - remaining lanes still to be emitted
//   data   - held beat, lane i is data[i]
//   word   - data of the lowest remaining lane
//   pick   - one-hot vector of that lane (all zero when mask is empty)
//   single - exactly one lane remains
module axis_lane_sel
  import axis_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]        mask,
  input  logic [N-1:0][W-1:0] data,
  output logic [W-1:0]        word,
  output logic [N-1:0]        pick,
  output logic                single
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if (N > MAX_LANES) begin : g_too_wide
    $fatal(1, "axis_lane_sel: N=%0d exceeds MAX_LANES=%0d", N, MAX_LANES);
  end

  logic [IDX_W-1:0] idx;

  assign idx    = IDX_W'(lowest_set_idx(MAX_LANES'(mask)));
  assign word   = data[idx];
  // Two's-complement trick isolates the lowest set bit.
  assign pick   = mask & (~mask + N'(1));
  assign single = is_one_hot(MAX_LANES'(mask));

endmodule

// File: rtl/axis_downsizer.sv
// AXI-Stream downsizer: splits BUS_W-wide beats into WORD_W-wide words,
// emitting kept lanes in ascending order and skipping empty lanes.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   s_valid/s_ready/s_last    - input beat handshake and packet end
//   s_keep, s_data            - per-lane keep bits and lane data
//   m_valid/m_ready/m_last    - output word handshake and packet end
//   m_data                    - current output word
//   null_beat                 - one-cycle pulse after an all-zero-keep beat
module axis_downsizer #(
  parameter int  WORD_W = 8,
  parameter int  BUS_W  = 32,
  localparam int WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic                                   s_last,
  input  logic [WORDS_PER_BEAT-1:0]              s_keep,
  input  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]  s_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [WORD_W-1:0]                      m_data,
  output logic                                   m_last,
  output logic                                   null_beat
);

  if (BUS_W % WORD_W != 0) begin : g_bad_width
    $fatal(1, "axis_downsizer: BUS_W=%0d is not a multiple of WORD_W=%0d", BUS_W, WORD_W);
  end

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] data_q;
  logic [WORDS_PER_BEAT-1:0]             mask_q;
  logic                                  last_q;
  logic                                  null_q;

  logic [WORDS_PER_BEAT-1:0] pick;
  logic                      single;
  logic                      s_fire;
  logic                      m_fire;

  axis_lane_sel #(
    .N (WORDS_PER_BEAT),
    .W (WORD_W)
  ) u_lane_sel (
    .mask   (mask_q),
    .data   (data_q),
    .word   (m_data),
    .pick   (pick),
    .single (single)
  );

  assign m_valid   = (mask_q != '0);
  assign m_last    = last_q & single;
  assign null_beat = null_q;

  // Only the final word may open the input in the same cycle; with more
  // words left, s_ready does not depend on m_ready at all.
  assign s_ready = rstn & ((mask_q == '0) | (m_ready & single));
  assign s_fire  = s_valid & s_ready;
  assign m_fire  = m_valid & m_ready;

  // NOTE: the data register is reset too, so m_data reads zero during reset
  // instead of leaking the last beat; it is a handful of flops, not a memory.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      mask_q <= '0;
      last_q <= 1'b0;
      null_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register sees the
      // pre-edge values of its neighbours regardless of statement order.
      null_q <= s_fire & (s_keep == '0);
      if (s_fire) begin
        // Also covers the final-word handshake: the new beat replaces it.
        data_q <= s_data;
        mask_q <= s_keep;
        last_q <= s_last;
      end else if (m_fire) begin
        mask_q <= mask_q & ~pick;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Self-checking bench for axis_downsizer (WORD_W=8, BUS_W=32): directed
// vectors with hand-computed values, then a randomized scoreboard run.
module tb_axis_downsizer;

  logic            clk = 1'b0;
  logic            rstn;
  logic            s_valid;
  logic            s_ready;
  logic            s_last;
  logic [3:0]      s_keep;
  logic [3:0][7:0] s_data;
  logic            m_valid;
  logic            m_ready;
  logic [7:0]      m_data;
  logic            m_last;
  logic            null_beat;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_downsizer #(
    .WORD_W (8),
    .BUS_W  (32)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_last    (s_last),
    .s_keep    (s_keep),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .null_beat (null_beat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [3:0] keep, input logic [31:0] data, input logic last);
    s_valid = 1'b1;
    s_keep  = keep;
    s_data  = data;
    s_last  = last;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] d, input logic l);
    @(negedge clk);
    check({tag, "_valid"}, m_valid, 1'b1);
    check({tag, "_data"},  m_data,  d);
    check({tag, "_last"},  m_last,  l);
  endtask

  logic [7:0] exp_d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic       exp_l [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  logic [8:0] sb [$];

  initial begin
    bit         go_idle;
    bit         have_beat;
    int         pkt;
    int         beat_in_pkt;
    int         nbeats;
    int         cycles;
    logic [8:0] e;

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_keep  = '0;
    s_data  = '0;
    m_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last",  m_last,  1'b0);
    check("rst_m_data",  m_data,  8'h00);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_null",    null_beat, 1'b0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("rel_s_ready", s_ready, 1'b1);

    // Full beat followed back-to-back by a second beat
    step();
    drive_beat(4'b1111, 32'h44332211, 1'b1);
    @(negedge clk);
    check("t1_s_ready_empty", s_ready, 1'b1);
    step();
    drive_beat(4'b1111, 32'h88776655, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expect_word($sformatf("t1_w%0d", i), exp_d[i], exp_l[i]);
      if (i < 3) check($sformatf("t1_s_ready_busy%0d", i), s_ready, 1'b0);
      if (i == 3) check("t1_s_ready_final", s_ready, 1'b1);
      go_idle = s_valid && s_ready;
      step();
      if (go_idle) s_valid = 1'b0;
    end
    @(negedge clk);
    check("t1_drained", m_valid, 1'b0);

    // Sparse keep: only lanes 1 and 3
    step();
    drive_beat(4'b1010, 32'hBB02AA01, 1'b1);
    step();
    s_valid = 1'b0;
    expect_word("t2_w0", 8'hAA, 1'b0);
    step();
    expect_word("t2_w1", 8'hBB, 1'b1);
    step();
    @(negedge clk);
    check("t2_drained", m_valid, 1'b0);

    // Back-pressure on word 2 of 4 with another beat waiting
    step();
    drive_beat(4'b1111, 32'hD4C3B2A1, 1'b1);
    step();
    s_valid = 1'b0;
    expect_word("t3_w0", 8'hA1, 1'b0);
    step();
    m_ready = 1'b0;
    drive_beat(4'b0001, 32'h000000E5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_word($sformatf("t3_hold%0d", i), 8'hB2, 1'b0);
      check($sformatf("t3_s_ready%0d", i), s_ready, 1'b0);
      step();
    end
    m_ready = 1'b1;
    expect_word("t3_w1", 8'hB2, 1'b0);
    step();
    expect_word("t3_w2", 8'hC3, 1'b0);
    step();
    expect_word("t3_w3", 8'hD4, 1'b1);
    check("t3_s_ready_final", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    expect_word("t3_next", 8'hE5, 1'b1);
    step();
    @(negedge clk);
    check("t3_drained", m_valid, 1'b0);

    // All-zero keep beat
    step();
    drive_beat(4'b0000, 32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("t4_null_before", null_beat, 1'b0);
    step();
    s_valid = 1'b0;
    @(negedge clk);
    check("t4_null_pulse", null_beat, 1'b1);
    check("t4_no_word",    m_valid,   1'b0);
    step();
    @(negedge clk);
    check("t4_null_end", null_beat, 1'b0);
    check("t4_no_word2", m_valid,   1'b0);

    // Reset after two of four words
    step();
    drive_beat(4'b1111, 32'h44332211, 1'b1);
    step();
    s_valid = 1'b0;
    expect_word("t5_w0", 8'h11, 1'b0);
    step();
    expect_word("t5_w1", 8'h22, 1'b0);
    step();
    rstn = 1'b0;
    #1;
    check("t5_rst_valid",  m_valid, 1'b0);
    check("t5_rst_data",   m_data,  8'h00);
    check("t5_rst_sready", s_ready, 1'b0);
    step();
    rstn = 1'b1;
    @(negedge clk);
    check("t5_rel_sready", s_ready, 1'b1);
    check("t5_rel_valid",  m_valid, 1'b0);
    step();
    drive_beat(4'b1111, 32'h98979695, 1'b0);
    step();
    s_valid = 1'b0;
    expect_word("t5_new_w0", 8'h95, 1'b0);
    step();
    expect_word("t5_new_w1", 8'h96, 1'b0);
    step();
    expect_word("t5_new_w2", 8'h97, 1'b0);
    step();
    expect_word("t5_new_w3", 8'h98, 1'b0);
    step();

    // Random packets against a scoreboard
    have_beat   = 1'b0;
    pkt         = 0;
    beat_in_pkt = 0;
    nbeats      = 1;
    cycles      = 0;
    while (!(pkt == 1000 && !have_beat && sb.size() == 0 && !m_valid) && cycles < 80000) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          check("rnd_extra_word", {24'h0, m_data}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("rnd_data", m_data, e[7:0]);
          check("rnd_last", m_last, e[8]);
        end
      end
      if (s_valid && s_ready) begin
        for (int l = 0; l < 4; l++) begin
          if (s_keep[l]) sb.push_back({s_last && (s_keep >> (l + 1)) == 4'b0, s_data[l]});
        end
        have_beat = 1'b0;
      end
      step();
      cycles++;
      m_ready = 1'($urandom_range(0, 1));
      if (!have_beat && pkt < 1000) begin
        if (beat_in_pkt == 0) nbeats = $urandom_range(1, 3);
        s_valid = 1'b0;
        s_keep  = 4'($urandom_range(0, 15));
        s_data  = $urandom;
        s_last  = (beat_in_pkt == nbeats - 1);
        if (s_last) begin
          beat_in_pkt = 0;
          pkt++;
        end else begin
          beat_in_pkt++;
        end
        have_beat = 1'b1;
      end
      if (!have_beat) s_valid = 1'b0;
      else if (!s_valid) s_valid = ($urandom_range(0, 99) < 20);
    end
    check("rnd_budget",   cycles < 80000, 1'b1);
    check("rnd_packets",  pkt, 1000);
    check("rnd_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_downsizer.md
AXIS_DOWNSIZER -- requirements
Module: axis_downsizer

Interface
REQ-001 SHALL have parameter WORD_W, default 8, width in bits of one word.
REQ-002 SHALL have parameter BUS_W, default 32, input beat width in bits.
REQ-003 SHALL have localparam WORDS_PER_BEAT, equal to BUS_W/WORD_W, giving input lanes per beat.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state samples on posedge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-007 SHALL have port s_ready, output, 1 bit: input beat accepted when high with s_valid.
REQ-008 SHALL have port s_last, input, 1 bit: final beat of packet.
REQ-009 SHALL have port s_keep, input, WORDS_PER_BEAT bits: lane i carries a word when bit i is 1.
REQ-010 SHALL have port s_data, input, [WORDS_PER_BEAT][WORD_W] packed: lane i is s_data[i].
REQ-011 SHALL have port m_valid, output, 1 bit: output word valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts the word.
REQ-013 SHALL have port m_data, output, WORD_W bits: current word.
REQ-014 SHALL have port m_last, output, 1 bit: final word of packet.
REQ-015 SHALL have port null_beat, output, 1 bit: one-cycle pulse when an all-zero-keep beat is consumed.

Function
REQ-016 SHALL hold one beat in registers data_q, mask_q (remaining kept lanes), last_q; the block is empty when mask_q==0.
REQ-017 SHALL drive m_valid = (mask_q!=0), and m_data = data_q[k], where k is the lowest set bit of mask_q.
REQ-018 SHALL drive m_last = last_q AND (mask_q has exactly one bit set).
REQ-019 SHALL emit kept lanes in ascending lane order and skip zero-keep lanes; sparse keep is legal.
REQ-020 SHALL compute s_ready combinationally as rstn AND (mask_q==0 OR (m_ready AND mask_q has exactly one bit set)), with no m_ready->s_ready path when more than one word remains.
REQ-021 SHALL clear bit k of mask_q on each m_valid&&m_ready.
REQ-022 SHALL, on s_valid&&s_ready, load data_q<=s_data, mask_q<=s_keep, last_q<=s_last, with the first word visible the next cycle (latency 1).
REQ-023 SHALL sustain one word per cycle across beat boundaries, with no bubble, when m_ready stays high.
REQ-024 SHALL hold m_data/m_last stable while m_valid&&!m_ready.
REQ-025 SHALL, when an accepted beat has s_keep==0, leave mask_q at 0, raise null_beat the following cycle for one cycle, and emit no word even if s_last=1.
REQ-026 SHALL make a simultaneous final-word handshake and new-beat accept replace the beat in the same edge.
REQ-027 SHALL treat BUS_W not a multiple of WORD_W as an elaboration-time $fatal.

Reset
REQ-028 SHALL, while rstn=0, force asynchronously mask_q=0, last_q=0, data_q=0, null_beat=0, so that m_valid=0, m_last=0, m_data=0, s_ready=0.
REQ-029 SHALL discard a partially drained beat on reset asserted mid-beat; after release, s_ready=1 in the first cycle.

Structure
REQ-030 SHALL place in shared package axis_pkg the function returning the lowest-set-bit index and the function testing for exactly one bit set.
REQ-031 SHALL place the lane selector (mask to index plus mux) in sub-module axis_lane_sel.

Verification (WORD_W=8, BUS_W=32)
REQ-032 SHALL cover: keep=4'b1111, data lanes 0..3 = 11,22,33,44 (hex), last=1, m_ready=1 -> 11,22,33,44 on 4 consecutive cycles, with m_last only on 44; a second beat's first word appears on cycle 5 with no gap.
REQ-033 SHALL cover: keep=4'b1010, lanes 1=AA and 3=BB, last=1 -> exactly AA then BB, with m_last on BB.
REQ-034 SHALL cover: m_ready low for 3 cycles on word 2 of 4 -> m_data held, s_ready=0 throughout, no word lost or duplicated.
REQ-035 SHALL cover: keep=4'b0000, last=1 -> null_beat high for exactly 1 cycle, m_valid stays 0.
REQ-036 SHALL cover: rstn pulsed low after 2 of 4 words -> m_valid drops immediately; the next beat starts at its lane 0.
REQ-037 SHALL cover: 1000 random packets (random keep, PROB_VALID=20 source, random m_ready) against a scoreboard -> output word sequence and m_last positions match exactly.
